// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN forward-propagation control path:
// datapath phase codes, Q-value fixed-point type and default state count.
package dqn_pkg;

  localparam int unsigned N_ST_DEF = 9;
  localparam int unsigned Q_W      = 16;

  // Signed Q6.10 activation value
  typedef logic signed [Q_W-1:0] q_t;

  localparam logic [3:0] CTRL_IDLE   = 4'd0;
  localparam logic [3:0] CTRL_CLR    = 4'd1;
  localparam logic [3:0] CTRL_HACC   = 4'd2;
  localparam logic [3:0] CTRL_HACT   = 4'd3;
  localparam logic [3:0] CTRL_OACC   = 4'd4;
  localparam logic [3:0] CTRL_OACT   = 4'd5;
  localparam logic [3:0] CTRL_ARGMAX = 4'd6;
  localparam logic [3:0] CTRL_DONE   = 4'd7;

  // State codes double as the ctrl codes driven to the datapath
  typedef enum logic [3:0] {
    StIdle   = CTRL_IDLE,
    StClr    = CTRL_CLR,
    StHacc   = CTRL_HACC,
    StHact   = CTRL_HACT,
    StOacc   = CTRL_OACC,
    StOact   = CTRL_OACT,
    StArgmax = CTRL_ARGMAX,
    StDone   = CTRL_DONE
  } state_e;

endpackage

// File: rtl/fwd_prop_seq_if.sv
// Request/result bundle between the agent controller (master) and the
// forward-propagation sequencer (slave).
interface fwd_prop_seq_if import dqn_pkg::*; #(
  parameter int unsigned W = Q_W
) ();

  logic                start;
  logic [3:0]          st_in;
  logic                abort;
  logic signed [W-1:0] q_1;
  logic signed [W-1:0] q_2;
  logic signed [W-1:0] q_3;
  logic signed [W-1:0] q_4;
  logic [3:0]          ctrl;
  logic [3:0]          step;
  logic [3:0]          st;
  logic                acc_clr;
  logic                busy;
  logic                done;
  logic                err;
  logic [1:0]          action;
  logic signed [W-1:0] q_max;

  modport master (
    output start, st_in, abort, q_1, q_2, q_3, q_4,
    input  ctrl, step, st, acc_clr, busy, done, err, action, q_max
  );

  modport slave (
    input  start, st_in, abort, q_1, q_2, q_3, q_4,
    output ctrl, step, st, acc_clr, busy, done, err, action, q_max
  );

endinterface

// File: rtl/qmax_scan.sv
// Sequential 4-entry signed max/argmax scan, one entry per enabled cycle.
// The result outputs already include the current cycle's compare.
module qmax_scan import dqn_pkg::*; #(
  parameter int unsigned W = Q_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [1:0]          idx,
  input  logic signed [W-1:0] q [4],
  output logic signed [W-1:0] max_nxt,
  output logic [1:0]          arg_nxt
);

  logic signed [W-1:0] max_q;
  logic [1:0]          arg_q;
  logic signed [W-1:0] sel;

  assign sel = q[idx];

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    max_nxt = max_q;
    arg_nxt = arg_q;
    if (load) begin
      max_nxt = sel;
      arg_nxt = idx;
    end else if (en && (sel > max_q)) begin
      max_nxt = sel;
      arg_nxt = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
      arg_q <= '0;
    end else begin
      max_q <= max_nxt;
      arg_q <= arg_nxt;
    end
  end

endmodule

// File: rtl/fwd_prop_seq.sv
// Forward-propagation sequencer: turns one start request into the datapath
// phase stream, then scans the four Q-values for the greedy action.
module fwd_prop_seq import dqn_pkg::*; #(
  parameter int unsigned N_ST    = N_ST_DEF,
  parameter int unsigned ACT_CYC = 1,
  parameter int unsigned W       = Q_W
) (
  input logic           clk,
  input logic           rst,
  fwd_prop_seq_if.slave bus
);

  localparam logic [3:0] StMax   = 4'(N_ST);
  localparam logic [2:0] ActLast = 3'(ACT_CYC - 1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic [3:0]          step_q, step_d;
  logic [3:0]          st_q, st_d;
  logic                err_q, err_d;
  logic [1:0]          action_q, action_d;
  logic signed [W-1:0] q_max_q, q_max_d;

  logic                st_ok;
  logic                scan_en;
  logic                scan_load;
  logic signed [W-1:0] q_vec [4];
  logic signed [W-1:0] scan_max;
  logic [1:0]          scan_arg;

  assign q_vec[0]  = bus.q_1;
  assign q_vec[1]  = bus.q_2;
  assign q_vec[2]  = bus.q_3;
  assign q_vec[3]  = bus.q_4;
  assign st_ok     = (bus.st_in != 4'd0) && (bus.st_in <= StMax);
  assign scan_en   = (state_q == StArgmax);
  assign scan_load = scan_en && (cnt_q[1:0] == 2'd0);

  qmax_scan #(
    .W (W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load),
    .en      (scan_en),
    .idx     (cnt_q[1:0]),
    .q       (q_vec),
    .max_nxt (scan_max),
    .arg_nxt (scan_arg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    step_d   = step_q;
    st_d     = st_q;
    err_d    = 1'b0;
    action_d = action_q;
    q_max_d  = q_max_q;

    // Abort from any busy state routes through one clear cycle back to idle
    if ((state_q != StIdle) && bus.abort) begin
      state_d = StClr;
      abort_d = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (st_ok) begin
              st_d    = bus.st_in;
              step_d  = (step_q == 4'd15) ? 4'd1 : step_q + 4'd1;
              abort_d = 1'b0;
              state_d = StClr;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StClr: begin
          state_d = abort_q ? StIdle : StHacc;
          abort_d = 1'b0;
        end
        StHacc: begin
          state_d = StHact;
          cnt_d   = '0;
        end
        StHact: begin
          if (cnt_q == ActLast) begin
            state_d = StOacc;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StOacc: begin
          state_d = StOact;
          cnt_d   = '0;
        end
        StOact: begin
          if (cnt_q == ActLast) begin
            state_d = StArgmax;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StArgmax: begin
          if (cnt_q[1:0] == 2'd3) begin
            state_d  = StDone;
            action_d = scan_arg;
            q_max_d  = scan_max;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      step_q   <= '0;
      st_q     <= '0;
      err_q    <= 1'b0;
      action_q <= '0;
      q_max_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      step_q   <= step_d;
      st_q     <= st_d;
      err_q    <= err_d;
      action_q <= action_d;
      q_max_q  <= q_max_d;
    end
  end

  assign bus.ctrl    = state_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.acc_clr = (state_q == StClr);
  assign bus.done    = (state_q == StDone);
  assign bus.err     = err_q;
  assign bus.step    = step_q;
  assign bus.st      = st_q;
  assign bus.action  = action_q;
  assign bus.q_max   = q_max_q;

endmodule

// File: tb/tb_fwd_prop_seq.sv
// Self-checking bench for fwd_prop_seq: timeline model checked every cycle
// plus directed passes with hand-computed expectations.
module tb_fwd_prop_seq;
  import dqn_pkg::*;

  localparam int NST = 9;
  localparam int ACT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_prop_seq_if #(.W(16)) bus ();

  fwd_prop_seq #(
    .N_ST    (NST),
    .ACT_CYC (ACT),
    .W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] seq [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pass is a timeline indexed by cycles since acceptance
  bit                m_active = 0;
  int                m_t = 0;
  bit                m_abortph = 0;
  logic [3:0]        m_step = '0;
  logic [3:0]        m_st = '0;
  bit                m_err = 0;
  logic [1:0]        m_action = '0;
  logic signed [15:0] m_qmax = '0;
  logic signed [15:0] m_qv [4];

  function automatic logic [3:0] sched(input int t);
    if (t == 1) return 4'd1;
    if (t == 2) return 4'd2;
    if (t <= 2 + ACT) return 4'd3;
    if (t == 3 + ACT) return 4'd4;
    if (t <= 3 + 2 * ACT) return 4'd5;
    if (t <= 7 + 2 * ACT) return 4'd6;
    return 4'd7;
  endfunction

  function automatic logic [3:0] exp_ctrl();
    if (m_abortph) return 4'd1;
    if (m_active) return sched(m_t);
    return 4'd0;
  endfunction

  initial begin
    logic [3:0] cur;
    int         i;
    int         best;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 0; m_t = 0; m_abortph = 0; m_step = '0; m_st = '0;
        m_err = 0; m_action = '0; m_qmax = '0;
      end else begin
        cur   = exp_ctrl();
        m_err = 0;
        if (cur == 4'd0) begin
          if (bus.start) begin
            if (bus.st_in >= 4'd1 && int'(bus.st_in) <= NST) begin
              m_active = 1; m_t = 1; m_st = bus.st_in;
              m_step = (m_step == 4'd15) ? 4'd1 : m_step + 4'd1;
            end else begin
              m_err = 1;
            end
          end
        end else if (bus.abort) begin
          m_abortph = 1;
          m_active  = 0;
        end else if (m_abortph) begin
          m_abortph = 0;
        end else begin
          if (cur == 4'd6) begin
            i = m_t - (4 + 2 * ACT);
            case (i)
              0:       m_qv[0] = bus.q_1;
              1:       m_qv[1] = bus.q_2;
              2:       m_qv[2] = bus.q_3;
              default: m_qv[3] = bus.q_4;
            endcase
            if (i == 3) begin
              best = 0;
              for (int k = 1; k < 4; k++) if (m_qv[k] > m_qv[best]) best = k;
              m_action = 2'(best);
              m_qmax   = m_qv[best];
            end
          end
          if (cur == 4'd7) m_active = 0;
          else m_t++;
        end
      end
    end
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        e = exp_ctrl();
        check("ctrl", 32'(bus.ctrl), 32'(e));
        check("busy", 32'(bus.busy), 32'(e != 4'd0));
        check("acc_clr", 32'(bus.acc_clr), 32'(e == 4'd1));
        check("done", 32'(bus.done), 32'(e == 4'd7));
        check("err", 32'(bus.err), 32'(m_err));
        check("step", 32'(bus.step), 32'(m_step));
        check("st", 32'(bus.st), 32'(m_st));
        check("action", 32'(bus.action), 32'(m_action));
        check("q_max", 32'($unsigned(bus.q_max)), 32'($unsigned(m_qmax)));
      end
    end
  end

  task automatic start_pass(input logic [3:0] s);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.st_in = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic set_q(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    bus.q_1 = a; bus.q_2 = b; bus.q_3 = c; bus.q_4 = d;
  endtask

  task automatic run_pass(input logic [3:0] s, input logic [1:0] act,
                          input logic [15:0] qm, input logic [3:0] stp);
    start_pass(s);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pass_ctrl", 32'(bus.ctrl), 32'(seq[i]));
      check("pass_acc_clr", 32'(bus.acc_clr), 32'(i == 0));
      check("pass_done", 32'(bus.done), 32'(i == 9));
    end
    check("pass_action", 32'(bus.action), 32'(act));
    check("pass_q_max", 32'($unsigned(bus.q_max)), 32'(qm));
    check("pass_step", 32'(bus.step), 32'(stp));
    check("pass_st", 32'(bus.st), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 32'(bus.ctrl), 32'd0);
    check({tag, "_step"}, 32'(bus.step), 32'd0);
    check({tag, "_st"}, 32'(bus.st), 32'd0);
    check({tag, "_acc_clr"}, 32'(bus.acc_clr), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_action"}, 32'(bus.action), 32'd0);
    check({tag, "_q_max"}, 32'($unsigned(bus.q_max)), 32'd0);
  endtask

  initial begin
    int  got;
    bit  found;
    bus.start = 1'b0; bus.st_in = '0; bus.abort = 1'b0;
    set_q(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // Illegal state indices
    start_pass(4'd0);
    @(negedge clk);
    check("err0_pulse", 32'(bus.err), 32'd1);
    check("err0_busy", 32'(bus.busy), 32'd0);
    check("err0_step", 32'(bus.step), 32'd0);
    @(negedge clk);
    check("err0_clear", 32'(bus.err), 32'd0);
    start_pass(4'd10);
    @(negedge clk);
    check("err10_pulse", 32'(bus.err), 32'd1);
    check("err10_busy", 32'(bus.busy), 32'd0);
    check("err10_step", 32'(bus.step), 32'd0);

    // Tie between q_2 and q_3 resolves to the lower index
    set_q(16'hFC00, 16'h0A00, 16'h0A00, 16'h0200);
    run_pass(4'd3, 2'd1, 16'h0A00, 4'd1);
    @(negedge clk);
    check("post_done_low", 32'(bus.done), 32'd0);
    check("post_action_held", 32'(bus.action), 32'd1);

    // Abort during HACT
    set_q(16'h0100, 16'h0100, 16'h0100, 16'h0700);
    start_pass(4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_hact", 32'(bus.ctrl), 32'd3);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_ctrl_clr", 32'(bus.ctrl), 32'd1);
    check("abort_acc_clr", 32'(bus.acc_clr), 32'd1);
    check("abort_step", 32'(bus.step), 32'd2);
    @(negedge clk);
    check("abort_ctrl_idle", 32'(bus.ctrl), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_action", 32'(bus.action), 32'd1);
    check("abort_q_max", 32'($unsigned(bus.q_max)), 32'h0A00);

    // All equal negative values
    set_q(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    run_pass(4'd7, 2'd0, 16'hFF00, 4'd3);

    // Asynchronous reset during ARGMAX
    set_q(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    start_pass(4'd2);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.ctrl == 4'd6) found = 1;
    end
    check("reach_argmax", 32'(found), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    bus.start = 1'b1;
    bus.st_in = 4'd4;
    @(negedge clk); #2;
    rst = 1'b1;

    // Start held high: sixteen passes, step wraps 15 -> 1
    got = 0;
    for (int c = 0; c < 16 * 11 + 40 && got < 16; c++) begin
      @(negedge clk);
      if (bus.done) begin
        check("wrap_step", 32'(bus.step), 32'((got % 15) + 1));
        check("wrap_action", 32'(bus.action), 32'd3);
        got++;
      end
    end
    bus.start = 1'b0;
    check("wrap_passes", 32'(got), 32'd16);
    repeat (4) @(negedge clk);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
